// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU pipeline.
//   S1 registers the request (operands, opcode, accumulator select).
//   S2 registers the result and flags; the consumer drains S2 with out_ready.
// Optional accumulator: define ALU_PIPE_ACC_EN to build it in. Without that
// macro usa_acc is ignored and acc reads constant zero.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   in_valid / in_ready  request handshake (in_ready is combinational)
//   variable1, variable2 operands A and B
//   comando              opcode
//   usa_acc              use the accumulator as operand A
//   out_valid / out_ready result handshake
//   respuesta            result
//   carry, zero, negative, overflow  result flags
//   acc                  accumulator value
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] variable1,
   input  logic [WIDTH-1:0] variable2,
   input  logic [2:0]       comando,
   input  logic             usa_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] respuesta,
   output logic             carry,
   output logic             zero,
   output logic             negative,
   output logic             overflow,
   output logic [WIDTH-1:0] acc
);

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_ANDN = 3'b100;
   localparam logic [2:0] OP_ORN  = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;

   // S1 operand stage
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [2:0]       s1_op_q, s1_op_d;

   // S2 result stage
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic             ovf_q, ovf_d;

   logic             accept;
   logic             s2_load;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;

   assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
   assign in_ready = !s1_valid_q || s2_load;
   assign accept   = in_valid && in_ready;

`ifdef ALU_PIPE_ACC_EN
   logic             s1_use_acc_q, s1_use_acc_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   // acc already holds the previous op's result when the next op reaches S2
   assign op_a = s1_use_acc_q ? acc_q : s1_a_q;
   assign acc  = acc_q;

   always_comb begin
      s1_use_acc_d = s1_use_acc_q;
      acc_d        = acc_q;
      if (accept)  s1_use_acc_d = usa_acc;
      if (s2_load) acc_d        = alu_res;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_use_acc_q <= 1'b0;
         acc_q        <= '0;
      end else begin
         s1_use_acc_q <= s1_use_acc_d;
         acc_q        <= acc_d;
      end
   end
`else
   logic unused_usa_acc;

   assign unused_usa_acc = usa_acc;
   assign op_a           = s1_a_q;
   assign acc            = '0;
`endif

   // ALU on S1 contents; borrow is the top bit of the extended difference
   always_comb begin
      sum     = {1'b0, op_a} + {1'b0, s1_b_q};
      diff    = {1'b0, op_a} - {1'b0, s1_b_q};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (s1_op_q)
         OP_AND:  alu_res = op_a & s1_b_q;
         OP_OR:   alu_res = op_a | s1_b_q;
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (op_a[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                      (sum[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_XOR:  alu_res = op_a ^ s1_b_q;
         OP_ANDN: alu_res = op_a & ~s1_b_q;
         OP_ORN:  alu_res = op_a | ~s1_b_q;
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (op_a[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                      (diff[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_SLT:  alu_res = WIDTH'(diff[WIDTH]);
         default: alu_res = '0;
      endcase
   end

   // Next state for both stages; a full, stalled pipe holds everything
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_op_d     = s1_op_q;
      out_valid_d = out_valid_q;
      res_d       = res_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      neg_d       = neg_q;
      ovf_d       = ovf_q;

      if (accept) begin
         s1_valid_d = 1'b1;
         s1_a_d     = variable1;
         s1_b_d     = variable2;
         s1_op_d    = comando;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end

      if (s2_load) begin
         out_valid_d = 1'b1;
         res_d       = alu_res;
         carry_d     = alu_c;
         zero_d      = (alu_res == '0);
         neg_d       = alu_res[WIDTH-1];
         ovf_d       = alu_v;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_op_q     <= '0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_op_q     <= s1_op_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign respuesta = res_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign negative  = neg_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8). Expected results are computed
// from a reference model when a request is accepted and compared in order
// when the result is taken. Works with or without ALU_PIPE_ACC_EN.
module tb_alu_pipe;

   localparam int unsigned W = 8;
`ifdef ALU_PIPE_ACC_EN
   localparam bit ACC_ON = 1'b1;
`else
   localparam bit ACC_ON = 1'b0;
`endif

   localparam logic [2:0] AND_ = 3'd0, OR_ = 3'd1, ADD = 3'd2, XOR_ = 3'd3;
   localparam logic [2:0] ANDN = 3'd4, ORN = 3'd5, SUB = 3'd6, SLT = 3'd7;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] variable1 = '0;
   logic [W-1:0] variable2 = '0;
   logic [2:0]   comando = '0;
   logic         usa_acc = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] respuesta;
   logic         carry, zero, negative, overflow;
   logic [W-1:0] acc;

   alu_pipe #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .variable1(variable1), .variable2(variable2),
      .comando(comando), .usa_acc(usa_acc),
      .out_valid(out_valid), .out_ready(out_ready),
      .respuesta(respuesta),
      .carry(carry), .zero(zero), .negative(negative), .overflow(overflow),
      .acc(acc)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] res;
      logic         c, z, n, v;
      int unsigned  acyc;
      bit           lat;
   } exp_t;

   exp_t         scb[$];
   exp_t         mon_e;
   int           n_checks = 0;
   int           n_fail = 0;
   logic [W-1:0] model_acc = '0;
   bit           chk_lat = 1'b0;
   bit           rnd_done = 1'b0;
   bit           prev_hold = 1'b0;
   logic [W+3:0] snap = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: arithmetic done on plain integers, overflow from signed range
   function automatic exp_t model(input logic [2:0] op, input int unsigned a, input int unsigned b);
      exp_t        e;
      int unsigned mask = (32'd1 << W) - 1;
      int unsigned r;
      int          sa, sbv, rs;
      sa  = (a >= (32'd1 << (W-1))) ? int'(a) - (1 << W) : int'(a);
      sbv = (b >= (32'd1 << (W-1))) ? int'(b) - (1 << W) : int'(b);
      e.c = 1'b0;
      e.v = 1'b0;
      case (op)
         AND_: r = a & b;
         OR_:  r = a | b;
         ADD: begin
            r   = (a + b) & mask;
            e.c = (a + b) > mask;
            rs  = sa + sbv;
            e.v = (rs > (1 << (W-1)) - 1) || (rs < -(1 << (W-1)));
         end
         XOR_: r = a ^ b;
         ANDN: r = a & ~b & mask;
         ORN:  r = (a | ~b) & mask;
         SUB: begin
            r   = (a - b) & mask;
            e.c = a < b;
            rs  = sa - sbv;
            e.v = (rs > (1 << (W-1)) - 1) || (rs < -(1 << (W-1)));
         end
         default: r = (a < b) ? 32'd1 : 32'd0;
      endcase
      e.res  = W'(r);
      e.z    = (r == 0);
      e.n    = r[W-1];
      e.acyc = 0;
      e.lat  = 1'b0;
      return e;
   endfunction

   // Present one request until accepted; expected result queued at acceptance
   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic u);
      exp_t e;
      bit   done = 1'b0;
      in_valid  = 1'b1;
      comando   = op;
      variable1 = a;
      variable2 = b;
      usa_acc   = u;
      for (int t = 0; t < 100 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            e         = model(op, 32'((u && ACC_ON) ? model_acc : a), 32'(b));
            model_acc = e.res;
            e.acyc    = cyc;
            e.lat     = chk_lat;
            scb.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) chk("accept_timeout", 32'(0), 32'(1));
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 60 && scb.size() != 0; t++) @(posedge clk);
      chk("drain_empty", 32'(scb.size()), 32'(0));
      @(posedge clk);
      #1;
   endtask

   // Output monitor: in-order compare on transfer, stability while stalled
   always @(negedge clk) begin
      if (reset) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold)
            chk("hold_stable", 32'({out_valid, respuesta, carry, zero, negative, overflow}),
                32'({1'b1, snap}));
         if (out_valid && out_ready) begin
            if (scb.size() == 0) begin
               chk("spurious_out", 32'(out_valid), 32'(0));
            end else begin
               mon_e = scb.pop_front();
               chk("respuesta", 32'(respuesta), 32'(mon_e.res));
               chk("carry", 32'(carry), 32'(mon_e.c));
               chk("zero", 32'(zero), 32'(mon_e.z));
               chk("negative", 32'(negative), 32'(mon_e.n));
               chk("overflow", 32'(overflow), 32'(mon_e.v));
               chk("acc", 32'(acc), ACC_ON ? 32'(mon_e.res) : 32'(0));
               if (mon_e.lat) chk("latency", cyc - mon_e.acyc, 32'(2));
            end
         end
         prev_hold = out_valid && !out_ready;
         snap      = {respuesta, carry, zero, negative, overflow};
      end
   end

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_respuesta", 32'(respuesta), 32'(0));
      chk("rst_flags", 32'({carry, zero, negative, overflow}), 32'(0));
      chk("rst_acc", 32'(acc), 32'(0));
      reset = 1'b0;

      // back-to-back directed ops with out_ready high: latency 2, 1 op/cycle
      chk_lat = 1'b1;
      send(ADD, 8'h00, 8'h05, 1'b1);
      send(ADD, 8'h00, 8'h05, 1'b1);
      send(ADD, 8'h00, 8'h05, 1'b1);
      send(ADD, 8'h02, 8'h03, 1'b1);
      send(ADD, 8'hF0, 8'h20, 1'b0);
      send(SUB, 8'h80, 8'h01, 1'b0);
      send(SLT, 8'h03, 8'h05, 1'b0);
      send(SLT, 8'h05, 8'h03, 1'b0);
      send(XOR_, 8'h5A, 8'h5A, 1'b0);
      send(AND_, 8'hCC, 8'hAA, 1'b0);
      send(OR_, 8'h0C, 8'hA0, 1'b0);
      send(ANDN, 8'hFF, 8'h0F, 1'b0);
      send(ORN, 8'h10, 8'hF0, 1'b0);
      send(SUB, 8'h00, 8'h01, 1'b0);
      send(ADD, 8'h7F, 8'h01, 1'b0);
      send(ADD, 8'h80, 8'h80, 1'b0);
      chk_lat = 1'b0;
      drain();

      // consumer stalls 3 cycles after the first result of a 4-op stream
      fork
         begin
            send(ADD, 8'h11, 8'h22, 1'b0);
            send(SUB, 8'h33, 8'h44, 1'b0);
            send(XOR_, 8'hF0, 8'h0F, 1'b0);
            send(OR_, 8'h01, 8'h80, 1'b0);
         end
         begin
            bit seen = 1'b0;
            for (int t = 0; t < 50 && !seen; t++) begin
               @(negedge clk);
               seen = out_valid;
            end
            chk("stall_first_result", 32'(seen), 32'(1));
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("stall_in_ready", 32'(in_ready), 32'(0));
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // random traffic with random backpressure and idle gaps
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
                    1'($urandom_range(0, 1)));
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain();

      // reset with both stages full: in-flight work discarded
      out_ready = 1'b0;
      send(ADD, 8'h12, 8'h34, 1'b1);
      send(SUB, 8'h56, 8'h07, 1'b0);
      chk("full_out_valid", 32'(out_valid), 32'(1));
      chk("full_in_ready", 32'(in_ready), 32'(0));
      #1;
      reset = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'(0));
      chk("midrst_respuesta", 32'(respuesta), 32'(0));
      chk("midrst_flags", 32'({carry, zero, negative, overflow}), 32'(0));
      chk("midrst_acc", 32'(acc), 32'(0));
      chk("midrst_in_ready", 32'(in_ready), 32'(1));
      scb.delete();
      model_acc = '0;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_stale_out", 32'(out_valid), 32'(0));
      end
      @(posedge clk);
      #1;
      chk_lat = 1'b1;
      send(ADD, 8'h09, 8'h01, 1'b1);
      chk_lat = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have ports variable1, variable2  input  WIDTH  operands A, B (unsigned unless stated).
REQ-007 SHALL have port comando  input  3  opcode.
REQ-008 SHALL have port usa_acc  input  1  substitute accumulator for A (see Configuration).
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port respuesta  output  WIDTH  result.
REQ-012 SHALL have ports carry, zero, negative, overflow  output  1 each  result flags.
REQ-013 SHALL have port acc  output  WIDTH  accumulator value.

Function
REQ-014 Opcodes SHALL be: 000 A&B; 001 A|B; 010 A+B; 011 A^B; 100 A&~B; 101 A|~B; 110 A-B; 111 (A<B unsigned) ? 1 : 0, zero-extended.
REQ-015 ADD/SUB SHALL wrap modulo 2^WIDTH.
REQ-016 carry SHALL be ADD carry-out, SUB borrow (1 when A<B unsigned), 0 for all other opcodes.
REQ-017 overflow SHALL be two's-complement signed overflow for ADD/SUB, 0 otherwise.
REQ-018 zero SHALL be 1 iff respuesta==0; negative SHALL equal respuesta[WIDTH-1].
REQ-019 Pipeline SHALL be two stages: S1 operand register (s1_valid), S2 result/flag register (out_valid).
REQ-020 Accept: transfer occurs when in_valid && in_ready; S1 captures variable1, variable2, comando, usa_acc.
REQ-021 s2_load = s1_valid && (!out_valid || out_ready); result computed from S1 contents registered into S2 on s2_load.
REQ-022 in_ready SHALL equal !s1_valid || s2_load (combinational, no dependency on in_valid).
REQ-023 S1 SHALL clear s1_valid when s2_load and no new accept occurs the same cycle.
REQ-024 out_valid SHALL clear on out_ready when !s2_load; respuesta and flags SHALL hold stable while out_valid && !out_ready.
REQ-025 Latency: accept in cycle N, out_valid first high in cycle N+2 given out_ready held high; throughput one op/cycle.
REQ-026 Full condition (s1_valid && out_valid && !out_ready): in_ready=0, no state changes, no data lost or duplicated.
REQ-027 Simultaneous accept and s2_load SHALL both occur in the same cycle (S1 refilled, S2 reloaded).
REQ-028 Results SHALL emerge in strict accept order.

Reset
REQ-029 On reset assertion, asynchronously: s1_valid=0, out_valid=0, respuesta=0, all flags=0, acc=0; in_ready SHALL read 1 after reset.
REQ-030 Reset mid-operation SHALL discard in-flight S1/S2 contents; no result for them SHALL appear after release.
REQ-031 First accept SHALL be possible on the first rising clk edge after reset deasserts.

Configuration
REQ-032 Macro ALU_PIPE_ACC_EN SHALL compile in the accumulator.
REQ-033 With ALU_PIPE_ACC_EN: acc SHALL load respuesta's next value on every s2_load; when S1 usa_acc=1, operand A at s2_load SHALL be current acc instead of captured variable1.
REQ-034 With ALU_PIPE_ACC_EN: back-to-back usa_acc ops SHALL each see the previous op's result (no hazard, no stall).
REQ-035 Without ALU_PIPE_ACC_EN: usa_acc SHALL be ignored, acc SHALL be constant 0, no accumulator flops.

Verification
REQ-036 WIDTH=8, ADD 0xF0+0x20, out_ready=1 -> respuesta=0x10, carry=1, overflow=0, out_valid 2 cycles after accept.
REQ-037 SUB 0x80-0x01 -> respuesta=0x7F, carry=0, overflow=1, negative=0; SLT 0x03,0x05 -> 0x01; XOR 0x5A^0x5A -> 0x00, zero=1.
REQ-038 Stream 4 ops, out_ready low 3 cycles after first result -> in_ready=0 once S1 full, results unchanged and in order after release.
REQ-039 ALU_PIPE_ACC_EN, acc=0: ADD usa_acc B=0x05 three consecutive cycles -> respuesta 0x05,0x0A,0x0F, acc=0x0F.
REQ-040 Assert reset with both stages valid -> out_valid=0, acc=0, respuesta=0 immediately; no stale result after release.
REQ-041 Without ALU_PIPE_ACC_EN, usa_acc=1 ADD 0x02+0x03 -> respuesta=0x05, acc=0.
